glb_iact_bank: RTL and testbench



---
 rtl/glb_iact_bank.sv | 133 +++++++++++++
 tb/tb_glb_iact_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_iact_bank.sv
// Input-activation bank in the global buffer. A DMA burst fills it, then it serves
// single-word reads for the west iact router with one cycle of latency.
module glb_iact_bank #(
    parameter int DATA_BITWIDTH     = 16,
    parameter int ADDR_BITWIDTH_GLB = 10,
    parameter int FILL_BASE         = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fill_start_i,
    input  logic [ADDR_BITWIDTH_GLB:0]   fill_len_i,
    input  logic [DATA_BITWIDTH-1:0]     fill_data_i,
    input  logic                         fill_enable_i,
    output logic                         fill_done_o,
    input  logic                         rd_req_i,
    input  logic [ADDR_BITWIDTH_GLB-1:0] rd_addr_i,
    output logic [DATA_BITWIDTH-1:0]     rd_data_o,
    output logic                         rd_enable_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int AW    = ADDR_BITWIDTH_GLB;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] BASE_ADDR = AW'(FILL_BASE);

    typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

    state_t state, state_next;

    logic [DATA_BITWIDTH-1:0] mem [DEPTH];

    logic [AW:0]   len, len_next;
    logic [AW:0]   valid_len, valid_len_next;
    logic [AW:0]   wr_cnt, wr_cnt_next;
    logic [AW-1:0] wr_ptr, wr_ptr_next;
    logic [AW:0]   fill_len_clamped;
    logic [AW-1:0] rd_offset;
    logic          rd_legal;
    logic          fill_accept;
    logic          mem_we;
    logic          done_next;
    logic          err_next;

    assign fill_len_clamped = (fill_len_i > DEPTH_LEN) ? DEPTH_LEN : fill_len_i;

    // Offset arithmetic wraps modulo the bank depth, so a fill may run past the top address.
    assign rd_offset = rd_addr_i - BASE_ADDR;
    assign rd_legal  = (state == READY) && ({1'b0, rd_offset} < valid_len);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        len_next       = len;
        valid_len_next = valid_len;
        wr_cnt_next    = wr_cnt;
        wr_ptr_next    = wr_ptr;
        done_next      = 1'b0;
        mem_we         = 1'b0;
        fill_accept    = 1'b0;
        case (state)
            IDLE, READY: begin
                if (fill_start_i) begin
                    fill_accept    = 1'b1;
                    len_next       = fill_len_clamped;
                    wr_ptr_next    = BASE_ADDR;
                    wr_cnt_next    = '0;
                    valid_len_next = '0;
                    if (fill_len_clamped == '0) begin
                        state_next = READY;
                        done_next  = 1'b1;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (fill_enable_i) begin
                    mem_we      = 1'b1;
                    wr_ptr_next = wr_ptr + 1'b1;
                    wr_cnt_next = wr_cnt + 1'b1;
                    if (wr_cnt == len - 1'b1) begin
                        state_next     = READY;
                        valid_len_next = len;
                        done_next      = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An illegal read in the same cycle as a restart still leaves the flag set.
    assign err_next = (fill_accept ? 1'b0 : err_o) | (rd_req_i & ~rd_legal);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            len         <= '0;
            valid_len   <= '0;
            wr_cnt      <= '0;
            wr_ptr      <= BASE_ADDR;
            fill_done_o <= 1'b0;
            err_o       <= 1'b0;
            rd_enable_o <= 1'b0;
            rd_data_o   <= '0;
        end else begin
            state       <= state_next;
            len         <= len_next;
            valid_len   <= valid_len_next;
            wr_cnt      <= wr_cnt_next;
            wr_ptr      <= wr_ptr_next;
            fill_done_o <= done_next;
            err_o       <= err_next;
            rd_enable_o <= rd_req_i;
            if (rd_req_i) begin
                rd_data_o <= rd_legal ? mem[rd_addr_i] : '0;
            end
        end
    end

    // NOTE: the array has no reset; valid_len gates every read, so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= fill_data_i;
        end
    end

    assign busy_o = (state == FILL);

endmodule

// File: tb/tb_glb_iact_bank.sv
// Bench for glb_iact_bank: directed fills and reads, with read responses checked by
// per-instance scoreboard monitors. A second instance uses FILL_BASE=1022 for wrap cases.
module tb_glb_iact_bank;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          fill_start, fill_enable, rd_req;
    logic [AW:0]   fill_len;
    logic [DW-1:0] fill_data;
    logic [AW-1:0] rd_addr;
    logic          fill_done, rd_enable, busy, err;
    logic [DW-1:0] rd_data;

    logic          w_fill_start, w_fill_enable, w_rd_req;
    logic [AW:0]   w_fill_len;
    logic [DW-1:0] w_fill_data;
    logic [AW-1:0] w_rd_addr;
    logic          w_fill_done, w_rd_enable, w_busy, w_err;
    logic [DW-1:0] w_rd_data;

    glb_iact_bank #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .FILL_BASE(0)) dut0 (
        .clk(clk), .reset(reset),
        .fill_start_i(fill_start), .fill_len_i(fill_len), .fill_data_i(fill_data),
        .fill_enable_i(fill_enable), .fill_done_o(fill_done),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_enable_o(rd_enable), .busy_o(busy), .err_o(err)
    );

    glb_iact_bank #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH_GLB(AW), .FILL_BASE(1022)) dut1 (
        .clk(clk), .reset(reset),
        .fill_start_i(w_fill_start), .fill_len_i(w_fill_len), .fill_data_i(w_fill_data),
        .fill_enable_i(w_fill_enable), .fill_done_o(w_fill_done),
        .rd_req_i(w_rd_req), .rd_addr_i(w_rd_addr), .rd_data_o(w_rd_data),
        .rd_enable_o(w_rd_enable), .busy_o(w_busy), .err_o(w_err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [4:0] stall_pat = 5'b11001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        rd_req  = 1'b1;
        rd_addr = a;
        q0.push_back('{data: d, err: e});
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
        w_rd_req  = 1'b1;
        w_rd_addr = a;
        q1.push_back('{data: d, err: e});
        cyc();
        w_rd_req = 1'b0;
    endtask

    task automatic fill0(input int n, input logic [DW-1:0] d0);
        fill_start = 1'b1;
        fill_len   = (AW+1)'(n);
        cyc();
        fill_start = 1'b0;
        check("fill_busy", busy, 1);
        check("fill_err_clear", err, 0);
        for (int i = 0; i < n; i++) begin
            fill_enable = 1'b1;
            fill_data   = d0 + DW'(i);
            cyc();
            check("fill_done", fill_done, (i == n - 1) ? 1 : 0);
        end
        fill_enable = 1'b0;
        check("fill_busy_after", busy, 0);
        cyc();
        check("fill_done_single", fill_done, 0);
    endtask

    // Monitors: every response must match the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_enable) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL rd0_unexpected: got data %0h with nothing expected", rd_data);
            end else begin
                e = q0.pop_front();
                check("rd0_data", rd_data, e.data);
                check("rd0_err", err, e.err);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (w_rd_enable) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL rd1_unexpected: got data %0h with nothing expected", w_rd_data);
            end else begin
                e = q1.pop_front();
                check("rd1_data", w_rd_data, e.data);
                check("rd1_err", w_err, e.err);
            end
        end
    end

    initial begin
        reset = 1'b0;
        fill_start = 0; fill_enable = 0; rd_req = 0; fill_len = '0; fill_data = '0; rd_addr = '0;
        w_fill_start = 0; w_fill_enable = 0; w_rd_req = 0; w_fill_len = '0; w_fill_data = '0; w_rd_addr = '0;
        repeat (2) cyc();
        check("rst_rd_enable", rd_enable, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_done", fill_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        cyc();

        // Basic 5-word fill, back-to-back read-out
        fill0(5, 16'h0011);
        for (int i = 0; i < 5; i++) rd0(AW'(i), 16'h0011 + DW'(i), 1'b0);
        cyc();
        check("rd_idle_enable", rd_enable, 0);
        check("rd_idle_hold", rd_data, 16'h0015);
        check("rd_idle_err", err, 0);

        // Stalled fill with an illegal read in the middle
        fill_start = 1'b1;
        fill_len   = 11'd3;
        cyc();
        fill_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fill_enable = stall_pat[k];
            fill_data   = 16'h0020 + DW'(k);
            if (k == 1) begin
                rd_req  = 1'b1;
                rd_addr = '0;
                q0.push_back('{data: 16'h0000, err: 1'b1});
            end
            cyc();
            rd_req = 1'b0;
            check("stall_busy", busy, (k < 4) ? 1 : 0);
            check("stall_done", fill_done, (k == 4) ? 1 : 0);
        end
        fill_enable = 1'b0;
        check("stall_err_sticky", err, 1);

        // Out-of-range reads after a 4-word fill
        fill0(4, 16'h0031);
        rd0(10'd3, 16'h0034, 1'b0);
        rd0(10'd7, 16'h0000, 1'b1);
        rd0(10'd4, 16'h0000, 1'b1);
        cyc();

        // Zero-length fill
        fill_start = 1'b1;
        fill_len   = '0;
        cyc();
        fill_start = 1'b0;
        check("zero_done", fill_done, 1);
        check("zero_busy", busy, 0);
        check("zero_err_clear", err, 0);
        cyc();
        check("zero_done_single", fill_done, 0);
        check("zero_busy_idle", busy, 0);
        rd0(10'd0, 16'h0000, 1'b1);

        // Over-long fill clamps to the bank depth
        fill_start = 1'b1;
        fill_len   = 11'd2047;
        cyc();
        fill_start = 1'b0;
        check("clamp_busy", busy, 1);
        check("clamp_err_clear", err, 0);
        for (int i = 0; i < 1024; i++) begin
            fill_enable = 1'b1;
            fill_data   = DW'(i) ^ 16'hA5A5;
            cyc();
            check("clamp_done", fill_done, (i == 1023) ? 1 : 0);
            check("clamp_busy_fill", busy, (i < 1023) ? 1 : 0);
        end
        fill_enable = 1'b0;
        rd0(10'd1023, 16'hA65A, 1'b0);
        rd0(10'd0, 16'hA5A5, 1'b0);
        rd0(10'd1, 16'hA5A4, 1'b0);

        // Wrapping fill on the FILL_BASE=1022 instance
        w_fill_start = 1'b1;
        w_fill_len   = 11'd4;
        cyc();
        w_fill_start = 1'b0;
        check("wrap_busy", w_busy, 1);
        for (int i = 0; i < 4; i++) begin
            w_fill_enable = 1'b1;
            w_fill_data   = 16'h0041 + DW'(i);
            cyc();
            check("wrap_done", w_fill_done, (i == 3) ? 1 : 0);
        end
        w_fill_enable = 1'b0;
        rd1(10'd0, 16'h0043, 1'b0);
        rd1(10'd1, 16'h0044, 1'b0);
        rd1(10'd1022, 16'h0041, 1'b0);
        rd1(10'd1023, 16'h0042, 1'b0);
        rd1(10'd2, 16'h0000, 1'b1);
        cyc();

        // Asynchronous reset in the middle of a fill with a read in flight
        fill_start = 1'b1;
        fill_len   = 11'd6;
        cyc();
        fill_start  = 1'b0;
        fill_enable = 1'b1;
        fill_data   = 16'h0061;
        rd_req      = 1'b1;
        rd_addr     = 10'd0;
        q0.push_back('{data: 16'h0000, err: 1'b1});
        cyc();
        fill_data = 16'h0062;
        rd_addr   = 10'd1;
        q0.push_back('{data: 16'h0000, err: 1'b1});
        cyc();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_err", err, 1);
        check("pre_rst_w_err", w_err, 1);
        fill_data = 16'h0063;
        rd_addr   = 10'd2;
        #2 reset = 1'b0;
        #1;
        check("async_rd_enable", rd_enable, 0);
        check("async_rd_data", rd_data, 0);
        check("async_done", fill_done, 0);
        check("async_busy", busy, 0);
        check("async_err", err, 0);
        check("async_w_err", w_err, 0);
        cyc();
        check("held_rd_enable", rd_enable, 0);
        rd_req      = 1'b0;
        fill_enable = 1'b0;
        reset       = 1'b1;
        cyc();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", fill_done, 0);
        check("post_rst_err", err, 0);
        check("post_rst_rd_enable", rd_enable, 0);
        rd0(10'd0, 16'h0000, 1'b1);

        repeat (3) cyc();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
